// File: rtl/xadac_pkg.sv
// xadac shared types and helpers.
//   IdT      : scoreboard ID carried by a load unit on AR/R
//   AddrT    : AXI address
//   VecDataT : one R beat of vector data
//   AxiIdT   : memory-side ID {requester index, IdT} for the default port count
package xadac_pkg;

  localparam int IdWidth   = 3;
  localparam int AddrWidth = 32;
  localparam int VecWidth  = 64;

  typedef logic [IdWidth-1:0]   IdT;
  typedef logic [AddrWidth-1:0] AddrT;
  typedef logic [VecWidth-1:0]  VecDataT;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int req_idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int NumReqDflt      = 2;
  localparam int ReqIdxWidthDflt = req_idx_width(NumReqDflt);

  typedef logic [ReqIdxWidthDflt+IdWidth-1:0] AxiIdT;

endpackage

// File: rtl/xadac_rr_arb.sv
// Combinational round-robin picker.
//   elig    : eligible requester mask
//   rr_ptr  : highest-priority index this cycle (owned by the parent)
//   gnt_idx : first eligible index at or after rr_ptr, with wrap-around
//   gnt_vld : at least one requester is eligible
module xadac_rr_arb
  import xadac_pkg::*;
#(
  parameter  int NumReq = 2,
  localparam int IdxW   = req_idx_width(NumReq)
) (
  input  logic [NumReq-1:0] elig,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [2*NumReq-1:0] rot;
  int                  pos;

  // Rotating a doubled mask puts rr_ptr at bit 0, so the lowest set bit of
  // the low half is the winner's distance from rr_ptr.
  always_comb begin
    rot     = {elig, elig} >> rr_ptr;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(rr_ptr) + k;
        if (pos >= NumReq) pos = pos - NumReq;
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/xadac_axi_rd_arb.sv
// Shares one AXI read port (AR + single-beat R) between NumReq load units.
//   s_ar_*  : per-requester AR channels; s_ar_ready is one-hot or zero
//   s_r_*   : R beat broadcast (id/data), s_r_valid one-hot to the owner
//   m_ar_*  : registered memory-side AR, ID = {requester index, requester ID}
//   m_r_*   : memory-side R, routed back by the upper ID bits
//   idle    : nothing outstanding and no AR pending
//   err     : sticky; set by an R beat to a bad index or an idle requester
module xadac_axi_rd_arb
  import xadac_pkg::*;
#(
  parameter  int NumReq      = 2,
  parameter  int MaxOut      = 4,
  localparam int ReqIdxWidth = req_idx_width(NumReq)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumReq-1:0][IdWidth-1:0]    s_ar_id,
  input  logic [NumReq-1:0][AddrWidth-1:0]  s_ar_addr,
  input  logic [NumReq-1:0]                 s_ar_valid,
  output logic [NumReq-1:0]                 s_ar_ready,
  output logic [IdWidth-1:0]                s_r_id,
  output logic [VecWidth-1:0]               s_r_data,
  output logic [NumReq-1:0]                 s_r_valid,
  input  logic [NumReq-1:0]                 s_r_ready,
  output logic [ReqIdxWidth+IdWidth-1:0]    m_ar_id,
  output logic [AddrWidth-1:0]              m_ar_addr,
  output logic                              m_ar_valid,
  input  logic                              m_ar_ready,
  input  logic [ReqIdxWidth+IdWidth-1:0]    m_r_id,
  input  logic [VecWidth-1:0]               m_r_data,
  input  logic                              m_r_valid,
  output logic                              m_r_ready,
  output logic                              idle,
  output logic                              err
);

  localparam int CntW = $clog2(MaxOut + 1);
  localparam int MIdW = ReqIdxWidth + IdWidth;

  logic                              m_ar_valid_q, m_ar_valid_d;
  logic [MIdW-1:0]                   m_ar_id_q, m_ar_id_d;
  AddrT                              m_ar_addr_q, m_ar_addr_d;
  logic                              err_q, err_d;
  logic [ReqIdxWidth-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0][CntW-1:0]       cnt_q, cnt_d;

  logic [NumReq-1:0]      elig;
  logic [ReqIdxWidth-1:0] gnt_idx;
  logic                   gnt_vld;
  logic                   slot_free, grant;
  logic [ReqIdxWidth-1:0] r_idx;
  logic                   r_idx_ok, r_bad, r_err, r_hs;
  logic                   all_zero;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = s_ar_valid[i] && (cnt_q[i] < CntW'(MaxOut));
    end
  end

  xadac_rr_arb #(.NumReq(NumReq)) u_rr_arb (
    .elig    (elig),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign slot_free = !m_ar_valid_q || m_ar_ready;
  assign grant     = !rst && slot_free && gnt_vld;

  always_comb begin
    s_ar_ready = '0;
    if (grant) s_ar_ready[gnt_idx] = 1'b1;
  end

  // R routing. A beat that cannot be attributed to an outstanding read is
  // swallowed (ready high) so the memory side never stalls on it.
  assign r_idx    = m_r_id[MIdW-1 -: ReqIdxWidth];
  assign r_idx_ok = int'(r_idx) < NumReq;
  assign r_bad    = r_idx_ok ? (cnt_q[r_idx] == '0) : 1'b1;
  assign r_err    = m_r_valid && r_bad;
  assign s_r_id   = m_r_id[IdWidth-1:0];
  assign s_r_data = m_r_data;

  always_comb begin
    s_r_valid = '0;
    m_r_ready = 1'b1;
    if (r_idx_ok && !r_bad) begin
      m_r_ready = s_r_ready[r_idx];
      s_r_valid[r_idx] = m_r_valid;
    end
  end

  assign r_hs = m_r_valid && !r_bad && m_r_ready;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign idle = rst || (all_zero && !m_ar_valid_q);

  always_comb begin
    m_ar_valid_d = m_ar_valid_q;
    m_ar_id_d    = m_ar_id_q;
    m_ar_addr_d  = m_ar_addr_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q || r_err;
    if (grant) begin
      m_ar_valid_d = 1'b1;
      m_ar_id_d    = {gnt_idx, s_ar_id[gnt_idx]};
      m_ar_addr_d  = s_ar_addr[gnt_idx];
      rr_ptr_d     = (int'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
    end else if (m_ar_valid_q && m_ar_ready) begin
      m_ar_valid_d = 1'b0;
    end
    for (int i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((grant && gnt_idx == ReqIdxWidth'(i)) && !(r_hs && r_idx == ReqIdxWidth'(i))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!(grant && gnt_idx == ReqIdxWidth'(i)) && (r_hs && r_idx == ReqIdxWidth'(i))) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ar_valid_q <= 1'b0;
      m_ar_id_q    <= '0;
      m_ar_addr_q  <= '0;
      err_q        <= 1'b0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      m_ar_valid_q <= m_ar_valid_d;
      m_ar_id_q    <= m_ar_id_d;
      m_ar_addr_q  <= m_ar_addr_d;
      err_q        <= err_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign m_ar_valid = m_ar_valid_q;
  assign m_ar_id    = m_ar_id_q;
  assign m_ar_addr  = m_ar_addr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_xadac_axi_rd_arb.sv
module tb_xadac_axi_rd_arb;
  import xadac_pkg::*;

  localparam int NR = 2;
  localparam int MO = 4;

  logic             clk;
  logic             rst;
  logic [1:0][2:0]  s_ar_id;
  logic [1:0][31:0] s_ar_addr;
  logic [1:0]       s_ar_valid;
  logic [1:0]       s_ar_ready;
  logic [2:0]       s_r_id;
  logic [63:0]      s_r_data;
  logic [1:0]       s_r_valid;
  logic [1:0]       s_r_ready;
  logic [3:0]       m_ar_id;
  logic [31:0]      m_ar_addr;
  logic             m_ar_valid;
  logic             m_ar_ready;
  logic [3:0]       m_r_id;
  logic [63:0]      m_r_data;
  logic             m_r_valid;
  logic             m_r_ready;
  logic             idle;
  logic             err;

  // staged inputs, applied at the next falling edge
  logic             nx_rst;
  logic [1:0][2:0]  nx_s_ar_id;
  logic [1:0][31:0] nx_s_ar_addr;
  logic [1:0]       nx_s_ar_valid;
  logic [1:0]       nx_s_r_ready;
  logic             nx_m_ar_ready;
  logic [3:0]       nx_m_r_id;
  logic [63:0]      nx_m_r_data;
  logic             nx_m_r_valid;

  // reference model state
  int          mcnt [2];
  bit          mvalid;
  logic [3:0]  mid;
  logic [31:0] maddr;
  int          mrr;
  bit          merr;

  int checks = 0;
  int errors = 0;

  xadac_axi_rd_arb #(.NumReq(NR), .MaxOut(MO)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_ar_id    (s_ar_id),
    .s_ar_addr  (s_ar_addr),
    .s_ar_valid (s_ar_valid),
    .s_ar_ready (s_ar_ready),
    .s_r_id     (s_r_id),
    .s_r_data   (s_r_data),
    .s_r_valid  (s_r_valid),
    .s_r_ready  (s_r_ready),
    .m_ar_id    (m_ar_id),
    .m_ar_addr  (m_ar_addr),
    .m_ar_valid (m_ar_valid),
    .m_ar_ready (m_ar_ready),
    .m_r_id     (m_r_id),
    .m_r_data   (m_r_data),
    .m_r_valid  (m_r_valid),
    .m_r_ready  (m_r_ready),
    .idle       (idle),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_stage();
    nx_rst        = 1'b0;
    nx_s_ar_valid = '0;
    nx_s_r_ready  = '0;
    nx_m_ar_ready = 1'b1;
    nx_m_r_valid  = 1'b0;
    nx_m_r_id     = '0;
    nx_m_r_data   = '0;
  endtask

  // One cycle: apply staged inputs, compare DUT to model, advance model.
  task automatic step();
    bit         found;
    int         g;
    int         idx;
    bit         bad;
    bit         hs;
    logic [1:0] e_sar;
    logic [1:0] e_srv;
    @(negedge clk);
    rst        = nx_rst;
    s_ar_id    = nx_s_ar_id;
    s_ar_addr  = nx_s_ar_addr;
    s_ar_valid = nx_s_ar_valid;
    s_r_ready  = nx_s_r_ready;
    m_ar_ready = nx_m_ar_ready;
    m_r_id     = nx_m_r_id;
    m_r_data   = nx_m_r_data;
    m_r_valid  = nx_m_r_valid;
    #1;
    found = 1'b0;
    g     = 0;
    if (!rst && (!mvalid || m_ar_ready)) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (mrr + k) % NR;
        if (!found && s_ar_valid[i] && mcnt[i] < MO) begin
          found = 1'b1;
          g     = i;
        end
      end
    end
    idx   = int'(m_r_id[3]);
    bad   = (mcnt[idx] == 0);
    e_sar = found ? 2'(1 << g) : 2'b00;
    e_srv = (m_r_valid && !bad) ? 2'(1 << idx) : 2'b00;
    chk("s_ar_ready", s_ar_ready, e_sar);
    chk("idle", idle, rst || (mcnt[0] == 0 && mcnt[1] == 0 && !mvalid));
    chk("s_r_valid", s_r_valid, e_srv);
    chk("s_r_id", s_r_id, m_r_id[2:0]);
    chk("s_r_data", s_r_data, m_r_data);
    if (m_r_valid) chk("m_r_ready", m_r_ready, bad ? 1'b1 : s_r_ready[idx]);
    chk("m_ar_valid", m_ar_valid, mvalid);
    if (mvalid) begin
      chk("m_ar_id", m_ar_id, mid);
      chk("m_ar_addr", m_ar_addr, maddr);
    end
    chk("err", err, merr);
    if (rst) begin
      mcnt[0] = 0; mcnt[1] = 0;
      mvalid = 1'b0; mid = '0; maddr = '0; mrr = 0; merr = 1'b0;
    end else begin
      if (m_r_valid && bad) merr = 1'b1;
      hs = m_r_valid && !bad && s_r_ready[idx];
      if (found) mcnt[g]++;
      if (hs) mcnt[idx]--;
      if (found) begin
        mvalid = 1'b1;
        mid    = {g[0], s_ar_id[g]};
        maddr  = s_ar_addr[g];
        mrr    = (g + 1) % NR;
      end else if (mvalid && m_ar_ready) begin
        mvalid = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; s_ar_id = '0; s_ar_addr = '0; s_ar_valid = '0; s_r_ready = '0;
    m_ar_ready = 1'b0; m_r_id = '0; m_r_data = '0; m_r_valid = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0; mvalid = 1'b0; mid = '0; maddr = '0; mrr = 0; merr = 1'b0;
    nx_s_ar_id = '0; nx_s_ar_addr = '0;
    idle_stage();
    nx_rst = 1'b1;
    step(); step();
    chk("rst_idle", idle, 1'b1);
    chk("rst_sar", s_ar_ready, 2'b00);

    // single request from requester 0
    idle_stage();
    nx_s_ar_valid = 2'b01; nx_s_ar_id[0] = 3'd3; nx_s_ar_addr[0] = 32'h1000;
    step();
    chk("t1_sar", s_ar_ready, 2'b01);
    nx_s_ar_valid = 2'b00;
    step();
    chk("t1_mvalid", m_ar_valid, 1'b1);
    chk("t1_mid", m_ar_id, 4'h3);
    chk("t1_maddr", m_ar_addr, 32'h1000);
    chk("t1_idle", idle, 1'b0);
    nx_m_r_valid = 1'b1; nx_m_r_id = 4'h3; nx_s_r_ready = 2'b01;
    step();
    chk("t1_rrdy", m_r_ready, 1'b1);
    chk("t1_srv", s_r_valid, 2'b01);
    idle_stage();
    step();
    chk("t1_idle_back", idle, 1'b1);

    // alternating grants from a fresh pointer
    nx_rst = 1'b1; step();
    idle_stage();
    nx_s_ar_valid = 2'b11; nx_s_ar_id[0] = 3'd3; nx_s_ar_id[1] = 3'd3; nx_s_ar_addr[1] = 32'h2000;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t2_grant", s_ar_ready, (n % 2 == 1) ? 2'b10 : 2'b01);
      if (n > 0) chk("t2_id", m_ar_id, ((n - 1) % 2 == 1) ? 4'hB : 4'h3);
    end

    // outstanding limit
    nx_s_ar_valid = 2'b01;
    step();
    chk("t3_id_last", m_ar_id, 4'hB);
    chk("t3_g3", s_ar_ready, 2'b01);
    step();
    chk("t3_g4", s_ar_ready, 2'b01);
    step();
    chk("t3_block", s_ar_ready, 2'b00);
    nx_s_ar_valid = 2'b11;
    step();
    chk("t3_req1", s_ar_ready, 2'b10);
    nx_s_ar_valid = 2'b01; nx_m_r_valid = 1'b1; nx_m_r_id = 4'h2; nx_s_r_ready = 2'b01;
    step();
    chk("t3_rblk", s_ar_ready, 2'b00);
    chk("t3_rrdy", m_r_ready, 1'b1);
    nx_m_r_valid = 1'b0; nx_s_r_ready = 2'b00;
    step();
    chk("t3_regrant", s_ar_ready, 2'b01);

    // backpressure on the AR slot
    nx_m_ar_ready = 1'b0; nx_s_ar_valid = 2'b10;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t4_sar", s_ar_ready, 2'b00);
      chk("t4_mvalid", m_ar_valid, 1'b1);
      chk("t4_mid", m_ar_id, 4'h3);
      chk("t4_maddr", m_ar_addr, 32'h1000);
    end
    nx_m_ar_ready = 1'b1;
    step();
    chk("t4_b2b", s_ar_ready, 2'b10);
    nx_s_ar_valid = 2'b00;
    step();
    chk("t4_mid_new", m_ar_id, 4'hB);
    chk("t4_maddr_new", m_ar_addr, 32'h2000);

    // R routing with a stalling requester
    nx_m_r_valid = 1'b1; nx_m_r_id = 4'hB; nx_m_r_data = 64'hA5A5A5A5A5A5A5A5; nx_s_r_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin
      step();
      chk("t5_srv", s_r_valid, 2'b10);
      chk("t5_srid", s_r_id, 3'd3);
      chk("t5_stall", m_r_ready, 1'b0);
      chk("t5_data", s_r_data, 64'hA5A5A5A5A5A5A5A5);
    end
    nx_s_r_ready = 2'b10;
    step();
    chk("t5_go", m_r_ready, 1'b1);
    idle_stage();
    step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int ri;
      nx_rst          = ($urandom_range(0, 199) == 0);
      nx_s_ar_valid   = 2'($urandom);
      nx_s_ar_id[0]   = 3'($urandom);
      nx_s_ar_id[1]   = 3'($urandom);
      nx_s_ar_addr[0] = $urandom;
      nx_s_ar_addr[1] = $urandom;
      nx_m_ar_ready   = ($urandom_range(0, 3) != 0);
      nx_s_r_ready    = 2'($urandom);
      nx_m_r_data     = {$urandom, $urandom};
      ri              = $urandom_range(0, 1);
      nx_m_r_id       = {ri[0], 3'($urandom)};
      nx_m_r_valid    = (mcnt[ri] > 0) && ($urandom_range(0, 1) == 1);
      step();
    end

    // drain everything
    idle_stage();
    nx_s_r_ready = 2'b11;
    for (int n = 0; n < 60 && (mcnt[0] + mcnt[1] > 0 || mvalid); n++) begin
      int ri;
      ri           = (mcnt[0] > 0) ? 0 : 1;
      nx_m_r_valid = (mcnt[ri] > 0);
      nx_m_r_id    = {ri[0], 3'($urandom)};
      step();
    end
    idle_stage();
    step();
    chk("drain_idle", idle, 1'b1);

    // stray R beat, then reset mid-flight
    nx_m_r_valid = 1'b1; nx_m_r_id = 4'hA;
    step();
    chk("t6_mrr", m_r_ready, 1'b1);
    chk("t6_srv", s_r_valid, 2'b00);
    chk("t6_err_pre", err, 1'b0);
    nx_m_r_valid = 1'b0; nx_s_ar_valid = 2'b11;
    step();
    chk("t6_err", err, 1'b1);
    nx_m_ar_ready = 1'b0;
    step();
    chk("t6_inflight", m_ar_valid, 1'b1);
    nx_rst = 1'b1;
    step();
    chk("t6_rst_idle", idle, 1'b1);
    chk("t6_rst_sar", s_ar_ready, 2'b00);
    idle_stage();
    step();
    chk("t6_mvalid0", m_ar_valid, 1'b0);
    chk("t6_mid0", m_ar_id, 4'h0);
    chk("t6_maddr0", m_ar_addr, 32'h0);
    chk("t6_err0", err, 1'b0);
    chk("t6_idle1", idle, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadac_axi_rd_arb.md
Name: xadac_axi_rd_arb

Overview:
Shares one AXI read port (AR + single-beat R) between NumReq xadac load units such as the vector-load unit.
- AR side: round-robin arbitration with a per-requester outstanding-read limit; the output AR is registered.
- Outgoing ID is the requester index prepended to the requester's scoreboard ID.
- R side: beats are demultiplexed back to the requester by the upper ID bits.
- Sits between the load units and the memory-side AXI port.

Parameters:
NumReq, 2, number of load units sharing the port (>=2)
MaxOut, 4, maximum outstanding reads per requester (>=1)
ReqIdxWidth, $clog2(NumReq), requester index width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_ar_id  in  NumReq x IdWidth  per-requester AR ID (IdT)
s_ar_addr  in  NumReq x AddrWidth  per-requester AR address (AddrT)
s_ar_valid  in  NumReq  per-requester AR valid
s_ar_ready  out  NumReq  per-requester AR ready (one-hot or zero)
s_r_id  out  IdWidth  R ID with requester index stripped, shared by all requesters
s_r_data  out  VecWidth  R data (VecDataT), broadcast to all requesters
s_r_valid  out  NumReq  per-requester R valid (one-hot or zero)
s_r_ready  in  NumReq  per-requester R ready
m_ar_id  out  ReqIdxWidth+IdWidth  {requester index, requester ID}
m_ar_addr  out  AddrWidth  AR address
m_ar_valid  out  1  AR valid
m_ar_ready  in  1  AR ready
m_r_id  in  ReqIdxWidth+IdWidth  R ID
m_r_data  in  VecWidth  R data
m_r_valid  in  1  R valid
m_r_ready  out  1  R ready
idle  out  1  all outstanding counters zero and m_ar_valid low
err  out  1  sticky protocol error

Behaviour:
- Reset: synchronous, active-high; overrides every other event in the same cycle.
  - Registers cleared: m_ar_valid, m_ar_id, m_ar_addr, err, rr_ptr, all outstanding counters cnt[i]; all set to 0.
  - Any in-flight AR is dropped.
  - Combinational outputs during reset: s_ar_ready=0, idle=1.
- AR register slot:
  - Free when !m_ar_valid, or when m_ar_valid && m_ar_ready in this cycle.
  - m_ar_id, m_ar_addr and m_ar_valid stay stable while m_ar_valid && !m_ar_ready.
- Eligibility: requester i is eligible when s_ar_valid[i] && cnt[i] < MaxOut.
- Grant:
  - When the slot is free, pick the first eligible requester g scanning from rr_ptr upward, with wrap-around.
  - s_ar_ready[g]=1 combinationally; s_ar_ready may depend on s_ar_valid.
  - On the next edge: m_ar_id <= {g, s_ar_id[g]}, m_ar_addr <= s_ar_addr[g], m_ar_valid <= 1, rr_ptr <= (g+1) mod NumReq.
  - No eligible requester: rr_ptr unchanged; m_ar_valid <= 0 if the slot was consumed, otherwise it holds.
- Latency and throughput: a grant in cycle t puts the request on m_ar in t+1; one AR per cycle is sustained when m_ar_ready=1.
- Counters (single-beat reads):
  - cnt[g] increments on grant.
  - cnt[idx] decrements on an R handshake to idx.
  - Both in the same cycle: cnt unchanged.
  - cnt never exceeds MaxOut, because grants are blocked at MaxOut.
- R routing (purely combinational, zero latency):
  - idx = m_r_id[top ReqIdxWidth bits].
  - s_r_valid[idx] = m_r_valid; all other s_r_valid bits are 0.
  - s_r_id = m_r_id low IdWidth bits; s_r_data = m_r_data.
  - m_r_ready = s_r_ready[idx].
- R errors:
  - Condition: idx >= NumReq, or cnt[idx]==0, while m_r_valid.
  - Response: m_r_ready=1 (beat dropped), no s_r_valid, err <= 1.
  - err stays set until reset.
- Fairness: a requester continuously eligible is granted within NumReq grants.

Decomposition:
- xadac_pkg additions:
  - ReqIdxWidth helper.
  - AxiIdT = logic [ReqIdxWidth+IdWidth-1:0].
  - Existing IdT, AddrT, VecDataT reused.
- Sub-module xadac_rr_arb: parameterised round-robin picker.
  - Inputs: eligible mask, rr_ptr.
  - Outputs: grant index and grant-valid.
  - Purely combinational; rr_ptr is owned by the parent.

Test Plan:
1. NumReq=2, IdWidth=3. Req0 id=3, addr=0x1000, m_ar_ready=1.
   -> s_ar_ready[0]=1 in cycle 0; cycle 1: m_ar_valid=1, m_ar_id=0x3, m_ar_addr=0x1000; cnt[0]=1, idle=0.
2. Both requesters valid continuously, m_ar_ready=1.
   -> grants 0,1,0,1; m_ar_id alternates 0x3/0xB for id=3; all four issued in 4 consecutive cycles.
3. MaxOut=4, no R returns.
   -> req0 granted 4 times then blocked; req1 still granted.
   -> One R beat with m_r_id=0x2 returns cnt[0] to 3; req0 is granted in the next free slot.
4. m_ar_ready=0 for 3 cycles with a request in the slot.
   -> m_ar_id/addr/valid stable; s_ar_ready=0 throughout; on ready, a new grant is loaded the same cycle (back-to-back).
5. Route m_r_id=0xB, data=0xA5..A5, s_r_ready[1]=0 for 2 cycles.
   -> s_r_valid=2'b10, s_r_id=3, m_r_ready=0 until s_r_ready[1]=1; cnt[1] decrements on that cycle.
6. R beat to requester 1 with cnt[1]=0.
   -> m_r_ready=1, s_r_valid=0, err=1 from next cycle.
   -> Then rst=1 mid-flight (m_ar_valid=1, counters nonzero): next cycle all outputs zero, idle=1, err=0.
